sample_mac_pipe: RTL

Parametrised, pipelined multiply-accumulate unit for the sample datapath. Computes unsigned × signed products with the same operand convention as the existing sample multipliers. Results are emitted either per beat (multiply mode) or once per group of beats (accumulate mode). Carries a valid bit through the pipeline, honours a global clock-enable stall, and sits between operand fetch and result write-back.

---
 rtl/sample_mac_pipe.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sample_mac_pipe.sv
// Pipelined unsigned x signed multiply-accumulate with per-beat or per-group results.
// Build option SAMPLE_MAC_SAT_EN: saturating accumulate/narrowing and a live sat_flag.
module sample_mac_pipe #(
  parameter int A_WIDTH    = 8,
  parameter int B_WIDTH    = 14,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 14,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [A_WIDTH-1:0]    din0,
  input  logic [B_WIDTH-1:0]    din1,
  input  logic                  acc_en,
  input  logic                  last,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  sat_flag
);

  // ---------------- multiplier pipeline ----------------
  logic [NUM_STAGE:1]           vld_q, vld_d;
  logic [NUM_STAGE:1]           en_q, en_d;
  logic [NUM_STAGE:1]           last_q, last_d;
  logic [A_WIDTH-1:0]           a_q, a_d;
  logic [B_WIDTH-1:0]           b_q, b_d;
  logic signed [ACC_WIDTH-1:0]  p_q [2:NUM_STAGE];
  logic signed [ACC_WIDTH-1:0]  p_d [2:NUM_STAGE];

  logic signed [ACC_WIDTH-1:0]  a_ext, b_ext, prod;

  // Exact product fits in A_WIDTH+B_WIDTH signed bits, so an ACC_WIDTH multiply is lossless.
  always_comb begin
    a_ext = {{(ACC_WIDTH-A_WIDTH){1'b0}}, a_q};
    b_ext = {{(ACC_WIDTH-B_WIDTH){b_q[B_WIDTH-1]}}, b_q};
    prod  = a_ext * b_ext;
  end

  always_comb begin
    vld_d    = vld_q;
    en_d     = en_q;
    last_d   = last_q;
    p_d      = p_q;
    vld_d[1]  = in_valid;
    en_d[1]   = acc_en;
    last_d[1] = last;
    a_d      = din0;
    b_d      = din1;
    for (int s = 2; s <= NUM_STAGE; s++) begin
      vld_d[s]  = vld_q[s-1];
      en_d[s]   = en_q[s-1];
      last_d[s] = last_q[s-1];
    end
    p_d[2] = prod;
    for (int s = 3; s <= NUM_STAGE; s++) p_d[s] = p_q[s-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      en_q   <= '0;
      last_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      for (int s = 2; s <= NUM_STAGE; s++) p_q[s] <= '0;
    end else if (ce) begin
      vld_q  <= vld_d;
      en_q   <= en_d;
      last_q <= last_d;
      a_q    <= a_d;
      b_q    <= b_d;
      p_q    <= p_d;
    end
  end

  // ---------------- accumulate stage ----------------
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]  res_q, res_d;
  logic                         acc_sat_q, acc_sat_d;
  logic                         res_sat_q, res_sat_d;
  logic                         res_vld_q, res_vld_d;
  logic signed [ACC_WIDTH-1:0]  p_tail, sum;
  logic                         add_ovf;

  assign p_tail = p_q[NUM_STAGE];

`ifdef SAMPLE_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic [ACC_WIDTH:0] sum_w;

  always_comb begin
    sum_w   = {acc_q[ACC_WIDTH-1], acc_q} + {p_tail[ACC_WIDTH-1], p_tail};
    add_ovf = sum_w[ACC_WIDTH] ^ sum_w[ACC_WIDTH-1];
    if (add_ovf) sum = sum_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    else         sum = sum_w[ACC_WIDTH-1:0];
  end
`else
  always_comb begin
    sum     = acc_q + p_tail;
    add_ovf = 1'b0;
  end
`endif

  // A multiply-mode beat inside an open group leaves acc and its sticky clamp bit alone.
  always_comb begin
    acc_d     = acc_q;
    acc_sat_d = acc_sat_q;
    res_d     = res_q;
    res_sat_d = res_sat_q;
    res_vld_d = 1'b0;
    if (vld_q[NUM_STAGE]) begin
      if (!en_q[NUM_STAGE]) begin
        res_d     = p_tail;
        res_sat_d = 1'b0;
        res_vld_d = 1'b1;
      end else if (!last_q[NUM_STAGE]) begin
        acc_d     = sum;
        acc_sat_d = acc_sat_q | add_ovf;
      end else begin
        res_d     = sum;
        res_sat_d = acc_sat_q | add_ovf;
        res_vld_d = 1'b1;
        acc_d     = '0;
        acc_sat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
      res_q     <= '0;
      res_sat_q <= 1'b0;
      res_vld_q <= 1'b0;
    end else if (ce) begin
      acc_q     <= acc_d;
      acc_sat_q <= acc_sat_d;
      res_q     <= res_d;
      res_sat_q <= res_sat_d;
      res_vld_q <= res_vld_d;
    end
  end

  // ---------------- narrowing / output stage ----------------
  logic signed [ACC_WIDTH-1:0]  r;
  logic [DOUT_WIDTH-1:0]        dout_n;
  logic                         narrow_ovf;
  logic                         out_valid_q, out_valid_d;
  logic [DOUT_WIDTH-1:0]        dout_q, dout_d;
  logic                         sat_q, sat_d;

  assign r = res_q >>> SHIFT;

`ifdef SAMPLE_MAC_SAT_EN
  logic [ACC_WIDTH-DOUT_WIDTH:0] r_hi;

  always_comb begin
    r_hi       = r[ACC_WIDTH-1:DOUT_WIDTH-1];
    narrow_ovf = !((&r_hi) || !(|r_hi));
    if (!narrow_ovf)            dout_n = r[DOUT_WIDTH-1:0];
    else if (r[ACC_WIDTH-1])    dout_n = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
    else                        dout_n = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  end
`else
  logic unused_r_hi;

  always_comb begin
    dout_n      = r[DOUT_WIDTH-1:0];
    narrow_ovf  = 1'b0;
    unused_r_hi = ^r[ACC_WIDTH-1:DOUT_WIDTH-1];
  end
`endif

  always_comb begin
    out_valid_d = res_vld_q;
    dout_d      = dout_q;
    sat_d       = sat_q;
    if (res_vld_q) begin
      dout_d = dout_n;
      sat_d  = res_sat_q | narrow_ovf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
    end else if (ce) begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign sat_flag  = sat_q;

endmodule
